// File: rtl/pkt_ingress_ctrl.sv
// Packet ingress controller: validates header length against the word stream,
// writes good packets to the buffer and rewinds bad ones with a drop pulse.
module pkt_ingress_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int PCK_LEN    = 12,
   parameter int MIN_LEN    = 2,
   parameter int MAX_LEN    = 1024
) (
   input  logic                  clk,
   input  logic                  hw_rst,
   input  logic                  sw_rst,
   input  logic                  in_valid,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  buffer_full,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_eop,
   output logic                  pck_drop,
   output logic [PCK_LEN-1:0]    drop_count,
   output logic                  pkt_commit,
   output logic [15:0]           good_pkt_cnt,
   output logic [15:0]           drop_pkt_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [PCK_LEN-1:0]    len_q, len_d;
   logic [PCK_LEN-1:0]    cnt_q, cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  wr_eop_q, wr_eop_d;
   logic                  pck_drop_q, pck_drop_d;
   logic [PCK_LEN-1:0]    drop_count_q, drop_count_d;
   logic                  pkt_commit_q, pkt_commit_d;
   logic [15:0]           good_cnt_q, good_cnt_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;

   logic [PCK_LEN-1:0]    hdr_len;
   logic [PCK_LEN-1:0]    cnt_next;
   logic                  len_ok;
   logic                  good_inc;
   logic                  drop_inc;

   assign hdr_len  = in_data[PCK_LEN-1:0];
   assign cnt_next = cnt_q + PCK_LEN'(1);
   assign len_ok   = (32'(hdr_len) >= MIN_LEN) && (32'(hdr_len) <= MAX_LEN);

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      wr_eop_d     = 1'b0;
      pck_drop_d   = 1'b0;
      drop_count_d = '0;
      pkt_commit_d = 1'b0;
      good_inc     = 1'b0;
      drop_inc     = 1'b0;

      if (in_valid) begin
         case (state_q)
            IDLE: begin
               if (in_sop) begin
                  // A lone header word can never satisfy MIN_LEN, so sop+eop is rejected here too.
                  if (!len_ok || buffer_full || in_eop) begin
                     drop_inc = 1'b1;
                     state_d  = in_eop ? IDLE : DISCARD;
                  end else begin
                     wr_en_d   = 1'b1;
                     wr_data_d = in_data;
                     len_d     = hdr_len;
                     cnt_d     = PCK_LEN'(1);
                     state_d   = RECV;
                  end
               end
            end
            RECV: begin
               if (buffer_full || in_sop) begin
                  pck_drop_d   = 1'b1;
                  drop_count_d = cnt_q;
                  drop_inc     = 1'b1;
                  state_d      = in_eop ? IDLE : DISCARD;
               end else if (cnt_next == len_q) begin
                  if (in_eop) begin
                     wr_en_d      = 1'b1;
                     wr_data_d    = in_data;
                     wr_eop_d     = 1'b1;
                     pkt_commit_d = 1'b1;
                     good_inc     = 1'b1;
                     state_d      = IDLE;
                  end else begin
                     // Length reached without eop: rewind now, swallow the tail.
                     pck_drop_d   = 1'b1;
                     drop_count_d = cnt_q;
                     drop_inc     = 1'b1;
                     state_d      = DISCARD;
                  end
               end else if (in_eop) begin
                  pck_drop_d   = 1'b1;
                  drop_count_d = cnt_q;
                  drop_inc     = 1'b1;
                  state_d      = IDLE;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_data_d = in_data;
                  cnt_d     = cnt_next;
               end
            end
            DISCARD: begin
               if (in_eop) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      good_cnt_d = (good_inc && !(&good_cnt_q)) ? good_cnt_q + 16'd1 : good_cnt_q;
      drop_cnt_d = (drop_inc && !(&drop_cnt_q)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

      // Software reset wins over whatever word is on the input this cycle.
      if (sw_rst) begin
         state_d      = IDLE;
         len_d        = '0;
         cnt_d        = '0;
         wr_en_d      = 1'b0;
         wr_data_d    = '0;
         wr_eop_d     = 1'b0;
         pck_drop_d   = 1'b0;
         drop_count_d = '0;
         pkt_commit_d = 1'b0;
         good_cnt_d   = '0;
         drop_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge hw_rst) begin
      if (!hw_rst) begin
         state_q      <= IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
         wr_eop_q     <= 1'b0;
         pck_drop_q   <= 1'b0;
         drop_count_q <= '0;
         pkt_commit_q <= 1'b0;
         good_cnt_q   <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         wr_eop_q     <= wr_eop_d;
         pck_drop_q   <= pck_drop_d;
         drop_count_q <= drop_count_d;
         pkt_commit_q <= pkt_commit_d;
         good_cnt_q   <= good_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_data      = wr_data_q;
   assign wr_eop       = wr_eop_q;
   assign pck_drop     = pck_drop_q;
   assign drop_count   = drop_count_q;
   assign pkt_commit   = pkt_commit_q;
   assign good_pkt_cnt = good_cnt_q;
   assign drop_pkt_cnt = drop_cnt_q;

endmodule

// File: doc/pkt_ingress_ctrl.md
# pkt_ingress_ctrl

Packet ingress controller that sits directly upstream of the packet internal buffer. It accepts a word stream with start/end markers and validates each packet against the length field in its header word. Good packets are written into the buffer. Bad packets are rewound through a one-cycle drop pulse that carries the number of words already written. It also produces a commit pulse per good packet and saturating good/drop statistics.

## Interface
Parameters:
- DATA_WIDTH, 32, word width.
- PCK_LEN, 12, width of the header length field and of drop_count.
- MIN_LEN, 2, minimum legal packet length in words, header included.
- MAX_LEN, 1024, maximum legal packet length in words.

Ports:
- clk  in  1  clock.
- hw_rst  in  1  asynchronous, active-low reset.
- sw_rst  in  1  synchronous, active-high software reset; same effect as hw_rst.
- in_valid  in  1  input word valid; there is no backpressure.
- in_sop  in  1  first word of packet (the header).
- in_eop  in  1  last word of packet.
- in_data  in  DATA_WIDTH  input word; on the header, in_data[PCK_LEN-1:0] is the packet length in words.
- buffer_full  in  1  full flag from the buffer.
- wr_en  out  1  buffer write strobe.
- wr_data  out  DATA_WIDTH  buffer write data.
- wr_eop  out  1  last word of a committed packet; driven to the buffer in_eop.
- pck_drop  out  1  one-cycle rewind request.
- drop_count  out  PCK_LEN  words to rewind; valid only with pck_drop, 0 otherwise.
- pkt_commit  out  1  one-cycle pulse, coincident with a good packet's wr_eop.
- good_pkt_cnt  out  16  committed packets, saturating at 16'hFFFF.
- drop_pkt_cnt  out  16  dropped or discarded packets, saturating.

## Operation
States:
- IDLE: wait for in_valid && in_sop.
- RECV: writing an accepted packet.
- DISCARD: swallow words until in_eop, with no writes.

Rules for each valid word:
- A valid word without sop in IDLE is ignored and is not counted.
- Header in IDLE, with len = in_data[PCK_LEN-1:0]:
  - len < MIN_LEN, len > MAX_LEN, or buffer_full: no write; drop_pkt_cnt++. Go to DISCARD, or stay in IDLE if in_eop is set on the same word.
  - Otherwise: write the word, latch len, set cnt = 1, go to RECV. A header with in_eop in this case is a length error: no write, drop_pkt_cnt++, stay IDLE.
- Words in RECV, with cnt_next = cnt + 1:
  - buffer_full: no write; pck_drop with drop_count = cnt; go to DISCARD, or IDLE if in_eop.
  - in_sop (missing eop): no write; pck_drop with drop_count = cnt; the new packet is also discarded; go to DISCARD, or IDLE if in_eop.
  - in_eop && cnt_next == len: write with wr_eop = 1; pkt_commit; good_pkt_cnt++; go to IDLE.
  - in_eop && cnt_next != len (short packet): no write; pck_drop with drop_count = cnt; go to IDLE.
  - !in_eop && cnt_next == len (long packet): no write; pck_drop with drop_count = cnt; go to DISCARD.
  - Otherwise: write the word; cnt = cnt_next.
- Every pck_drop also increments drop_pkt_cnt.
- cnt is PCK_LEN bits wide. It cannot wrap because it is bounded by len ≤ MAX_LEN < 2^PCK_LEN.
- wr_en and pck_drop are never both high in the same cycle.
- DISCARD ignores in_sop and leaves on in_eop.
- With in_valid low, state and cnt hold.

## Timing
- All outputs are registered, with one cycle of latency from the input word to wr_en, wr_data, wr_eop, pck_drop, drop_count and pkt_commit.
- Back-to-back packets are allowed: the header of packet N+1 may arrive in the cycle after the eop of packet N, with no gap.
- buffer_full is sampled in the same cycle as the input word.
- Reset values (hw_rst low or sw_rst high): state IDLE, cnt 0, all strobes 0, wr_data 0, drop_count 0, both statistics counters 0.
- Reset mid-packet aborts the packet silently, with no pck_drop, because the buffer is reset with it.
- sw_rst takes priority over the input stream in its cycle.

## Test plan
- Header len = 4, then 3 words with eop on the 4th word → 4 wr_en cycles, each 1 cycle after its input; wr_eop and pkt_commit on the 4th; good_pkt_cnt = 1.
- Header len = 5, eop on the 3rd word → 2 writes, then pck_drop with drop_count = 2 and no write in the 3rd output cycle; drop_pkt_cnt = 1.
- Header len = 3, no eop on the 3rd word, eop on the 6th word → 2 writes, pck_drop with drop_count = 2, words 3–6 not written, state IDLE after the 6th word.
- buffer_full asserted on the 3rd word of a 6-word packet → pck_drop with drop_count = 2; the remaining words are discarded.
- Header len = 1 (below MIN_LEN) and header len = 2000 (above MAX_LEN) → zero writes and no pck_drop; drop_pkt_cnt increments by 2.
- hw_rst pulsed low in the middle of a 4-word packet, then a clean 2-word packet → no pck_drop; the clean packet commits; good_pkt_cnt = 1 (both counters were cleared by the reset).
